// File: rtl/riscv_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_muldiv_pkg
//  Description : Shared definitions for the RV32M iterative multiply/divide
//                unit: default width, funct3 op encodings, FSM state codes
//                and operand-signedness helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_muldiv_pkg;

  localparam int c_XLEN_DEFAULT = 32;

  typedef logic [2:0] funct3_t;

  // RV32M funct3 encodings
  localparam funct3_t c_F3_MUL    = 3'd0;
  localparam funct3_t c_F3_MULH   = 3'd1;
  localparam funct3_t c_F3_MULHSU = 3'd2;
  localparam funct3_t c_F3_MULHU  = 3'd3;
  localparam funct3_t c_F3_DIV    = 3'd4;
  localparam funct3_t c_F3_DIVU   = 3'd5;
  localparam funct3_t c_F3_REM    = 3'd6;
  localparam funct3_t c_F3_REMU   = 3'd7;

  // FSM state encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_CALC = 2'd1;
  localparam logic [1:0] c_ST_FIX  = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  // operand_a is interpreted as signed for MULH, MULHSU, DIV, REM
  function automatic logic f_a_signed(input funct3_t f3);
    return (f3 == c_F3_MULH) || (f3 == c_F3_MULHSU) ||
           (f3 == c_F3_DIV)  || (f3 == c_F3_REM);
  endfunction

  // operand_b is interpreted as signed for MULH, DIV, REM
  function automatic logic f_b_signed(input funct3_t f3);
    return (f3 == c_F3_MULH) || (f3 == c_F3_DIV) || (f3 == c_F3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_muldiv_if
//  Description : Request/response bundle of the multiply/divide unit.
//                master : issuing pipeline (drives start/flush/op/operands)
//                slave  : riscv_muldiv (drives busy/done/result)
//  Ports       : start, flush, funct3, operand_a, operand_b  (master->slave)
//                busy, done, result                          (slave->master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_muldiv_if #(
  parameter int XLEN = riscv_muldiv_pkg::c_XLEN_DEFAULT
) ();
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, operand_a, operand_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, operand_a, operand_b,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/riscv_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_div_step
//  Description : One restoring-division iteration. Shifts the next dividend
//                bit (MSB of i_quo) into the partial remainder, subtracts the
//                divisor when it fits and shifts the quotient bit into o_quo.
//  Ports       : i_rem (partial remainder), i_quo (dividend/quotient shift
//                register), i_div (divisor) -> o_rem, o_quo
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_div_step #(
  parameter int XLEN = 32
) (
  input  wire logic [XLEN-1:0] i_rem,
  input  wire logic [XLEN-1:0] i_quo,
  input  wire logic [XLEN-1:0] i_div,
  output logic      [XLEN-1:0] o_rem,
  output logic      [XLEN-1:0] o_quo
);
  logic [XLEN:0] w_part;
  logic [XLEN:0] w_diff;

  assign w_part = {i_rem, i_quo[XLEN-1]};
  assign w_diff = w_part - {1'b0, i_div};

  // The partial remainder stays below the divisor, so a borrow shows up in
  // the top bit of the difference and the kept remainder always fits XLEN.
  assign o_rem = w_diff[XLEN] ? w_part[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], ~w_diff[XLEN]};
endmodule
`default_nettype wire

// File: rtl/riscv_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_muldiv
//  Description : Iterative RV32M multiply/divide unit. One shared FSM runs a
//                shift-add multiply or restoring divide over operand
//                magnitudes for XLEN cycles, then applies sign correction.
//                Divide-by-zero and signed overflow complete immediately.
//  Ports       : clk, rst (async, active-high), bus (riscv_muldiv_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN = c_XLEN_DEFAULT
) (
  input wire logic       clk,
  input wire logic       rst,
  riscv_muldiv_if.slave  bus
);
  localparam int              c_CNT_W    = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_f3;
  logic [XLEN-1:0]    r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]    r_lo;      // multiplier->product low / dividend->quotient
  logic [XLEN-1:0]    r_opnd;    // multiplicand / divisor magnitude
  logic               r_neg_res; // negate product or quotient in FIX
  logic               r_neg_rem; // negate remainder in FIX
  logic [XLEN-1:0]    r_result;

  // ---- request decode ------------------------------------------------------
  logic            w_a_neg, w_b_neg, w_is_div, w_div_zero, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_fast_res;

  assign w_a_neg    = f_a_signed(bus.funct3) & bus.operand_a[XLEN-1];
  assign w_b_neg    = f_b_signed(bus.funct3) & bus.operand_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -bus.operand_a : bus.operand_a;
  assign w_b_mag    = w_b_neg ? -bus.operand_b : bus.operand_b;
  assign w_is_div   = bus.funct3[2];
  assign w_div_zero = w_is_div && (bus.operand_b == '0);
  // DIV/REM only (funct3[0]==0): MIN / -1 overflows
  assign w_ovf      = w_is_div && !bus.funct3[0] &&
                      (bus.operand_a == c_MIN_NEG) && (bus.operand_b == '1);
  // funct3[1] selects the remainder for divide ops
  assign w_fast_res = w_div_zero ? (bus.funct3[1] ? bus.operand_a : '1)
                                 : (bus.funct3[1] ? '0 : bus.operand_a);

  // ---- iteration datapath --------------------------------------------------
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN-1:0] w_div_rem, w_div_quo;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

  riscv_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem (r_hi),
    .i_quo (r_lo),
    .i_div (r_opnd),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  // ---- sign correction and result select -----------------------------------
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_fix_res;

  assign w_prod_s  = r_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo_s   = r_neg_res ? -r_lo : r_lo;
  assign w_rem_s   = r_neg_rem ? -r_hi : r_hi;
  assign w_fix_res = r_f3[2] ? (r_f3[1] ? w_rem_s : w_quo_s)
                             : ((r_f3 == c_F3_MUL) ? w_prod_s[XLEN-1:0]
                                                   : w_prod_s[2*XLEN-1:XLEN]);

  // ---- shared sequencer ----------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else if (bus.flush) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.start) begin
            r_f3      <= bus.funct3;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            // multiply shifts the multiplier out of r_lo; divide shifts the
            // dividend out of r_lo
            r_lo      <= w_is_div ? w_a_mag : w_b_mag;
            r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
            if (w_div_zero || w_ovf) begin
              r_result <= w_fast_res;
              r_state  <= c_ST_DONE;
            end else begin
              r_state  <= c_ST_CALC;
            end
          end
        end
        c_ST_CALC: begin
          if (r_f3[2]) begin
            r_hi <= w_div_rem;
            r_lo <= w_div_quo;
          end else begin
            {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
          end
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= c_ST_FIX;
          end else begin
            r_cnt   <= r_cnt + c_CNT_W'(1);
          end
        end
        c_ST_FIX: begin
          r_result <= w_fix_res;
          r_state  <= c_ST_DONE;
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != c_ST_IDLE);
  assign bus.done   = (r_state == c_ST_DONE);
  assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_muldiv
//  Description : Self-checking bench for riscv_muldiv. Issued operations push
//                their expected result and completion cycle into a queue; a
//                monitor pops and compares on every done pulse. Cycle index k
//                is the clock period that ends at edge T0+k (T0 = start edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv;
  import riscv_muldiv_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_muldiv_if #(.XLEN(XLEN)) bus ();

  riscv_muldiv #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          idx;   // cycle index in which done must be seen
    int          t0;    // number of the start edge
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        m_e;
  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---- reference model: RV32M rules evaluated with 64-bit arithmetic -------
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) ||
           (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  // ---- monitor -------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 want=0 result=%0h", bus.result);
      end else begin
        m_e = sbq.pop_front();
        chk({m_e.name, " result"}, bus.result, m_e.res);
        chk({m_e.name, " done_cycle"}, cyc - m_e.t0 + 1, m_e.idx);
      end
    end
  end

  // ---- driver --------------------------------------------------------------
  // Returns at the negedge inside cycle index 'hold' (start held that long).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input int hold, input logic [31:0] want, input string name);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL %s idle_wait got=busy want=idle", name);
    end
    bus.funct3    = f3;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    if (push) begin
      e.res  = want;
      e.idx  = is_fast(f3, a, b) ? 1 : XLEN + 2;
      e.t0   = cyc + 1;
      e.name = name;
      sbq.push_back(e);
      last_res = want;
    end
    @(negedge clk);
    // operands changed while start stays high must not disturb the operation
    bus.operand_a = ~a;
    bus.operand_b = a ^ b;
    bus.funct3    = ~f3;
    repeat (hold - 1) @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s timeout got=pending want=done", name);
      sbq.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int          bad;
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          kind;

    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.operand_a = '0; bus.operand_b = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset result", bus.result, 0);
    rst = 1'b0;

    // MUL 7 x -3 with busy/done trace over cycles 1..34
    issue(c_F3_MUL, 32'd7, 32'hFFFF_FFFD, 1, 1, 32'hFFFF_FFEB, "mul_7x-3");
    bad = 0;
    for (int k = 1; k <= 34; k++) begin
      if (bus.busy !== 1'b1 || bus.done !== (k == 34)) bad++;
      if (k < 34) @(negedge clk);
    end
    chk("mul busy_done_trace_errs", bad, 0);
    @(negedge clk);
    chk("mul busy_after_done", bus.busy, 0);
    wait_done("mul_7x-3");

    issue(c_F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFE, "mulhu_ff");
    wait_done("mulhu_ff");
    issue(c_F3_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'h0000_0000, "mulh_ff");
    wait_done("mulh_ff");
    issue(c_F3_DIV, 32'hFFFF_FFF9, 32'd2, 1, 1, 32'hFFFF_FFFD, "div_-7/2");
    wait_done("div_-7/2");
    issue(c_F3_REM, 32'hFFFF_FFF9, 32'd2, 1, 1, 32'hFFFF_FFFF, "rem_-7/2");
    wait_done("rem_-7/2");
    issue(c_F3_DIVU, 32'd5, 32'd0, 1, 1, 32'hFFFF_FFFF, "divu_5/0");
    wait_done("divu_5/0");
    issue(c_F3_REM,  32'd5, 32'd0, 1, 1, 32'd5, "rem_5/0");
    wait_done("rem_5/0");
    issue(c_F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h8000_0000, "div_ovf");
    wait_done("div_ovf");
    issue(c_F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0, "rem_ovf");
    wait_done("rem_ovf");

    // flush sampled at edge T0+10 of a DIV
    issue(c_F3_DIV, 32'd1000, 32'd7, 0, 1, 32'h0, "div_flush");
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy_at_T0+11", bus.busy, 0);
    chk("flush result_kept", bus.result, last_res);
    repeat (40) @(negedge clk);
    chk("flush result_after_wait", bus.result, last_res);
    issue(c_F3_DIVU, 32'd1000, 32'd7, 1, 1, 32'd142, "divu_after_flush");
    wait_done("divu_after_flush");

    // start held high for several busy cycles with changing operands
    issue(c_F3_REMU, 32'd1000, 32'd7, 1, 5, 32'd6, "remu_start_held");
    wait_done("remu_start_held");

    // asynchronous reset between edges mid-operation
    issue(c_F3_MUL, 32'd12345, 32'd678, 0, 1, 32'h0, "mul_reset");
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst busy", bus.busy, 0);
    chk("async_rst result", bus.result, 0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst result", bus.result, 0);

    // randomized back-to-back operations against the model
    for (int i = 0; i < 60; i++) begin
      f3   = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      a    = $urandom();
      b    = $urandom();
      case (kind)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($signed(8'($urandom()))); b = 32'($signed(4'($urandom()))); end
        default: ;
      endcase
      issue(f3, a, b, 1, 1, ref_res(f3, a, b), $sformatf("rand%0d_f%0d", i, f3));
    end
    wait_done("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
